// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with a 2-entry skid buffer, masked flush bubble and saturating event counters
module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] BUBBLE    = '0,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;
  logic              accept, issue;
  assign in_ready  = (state_q != TWO) && !stall;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready && !stall;
  assign flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  assign stall_cnt_d = (stall && !flush && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = (BUBBLE & ~KEEP_MASK) | (in_data & KEEP_MASK);
    end else if (!stall) begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: if (accept && issue) begin
          main_d = in_data;
        end else if (issue) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = in_data;
        end
        TWO: if (issue) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue-based reference model
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam int          CW  = 2;
  localparam logic [31:0] BUB = 32'h0000_0013;
  localparam logic [31:0] KM  = 32'hFFFF_0000;
  logic          clk = 0, rst_n = 0, flush = 0, stall = 0, in_valid = 0, out_ready = 0;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data = '0, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] flush_cnt, stall_cnt;
  int n_cmp = 0, n_err = 0;
  logic [31:0] mq[$];
  logic [31:0] empty_data = BUB;
  int fc = 0, sc = 0;

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB), .KEEP_MASK(KM), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    empty_data = BUB;
    fc = 0;
    sc = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    {flush, stall, in_valid, out_ready} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // one cycle: drive, compare against the model, clock, advance the model
  task automatic step(input logic fl, input logic st, input logic iv, input logic [31:0] id, input logic ordy);
    bit acc, iss;
    flush = fl; stall = st; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data", out_data, mq.size() > 0 ? mq[0] : empty_data);
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2 && !st));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("flush_cnt", 32'(flush_cnt), 32'(fc));
    chk("stall_cnt", 32'(stall_cnt), 32'(sc));
    chk("invariant", 32'(occupancy <= 2 && ((occupancy != 0) == out_valid)), 32'd1);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      empty_data = (BUB & ~KM) | (id & KM);
      fc = (fc == 3) ? 3 : fc + 1;
    end else if (st) begin
      sc = (sc == 3) ? 3 : sc + 1;
    end else begin
      acc = iv && mq.size() < 2;
      iss = mq.size() > 0 && ordy;
      if (iss) void'(mq.pop_front());
      if (acc) mq.push_back(id);
      if (iss && mq.size() == 0) empty_data = BUB;
    end
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_data", out_data, BUB);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    // streaming
    step(0, 0, 1, 32'h11, 1);
    chk("stream_first", out_data, 32'h11);
    step(0, 0, 1, 32'h22, 1);
    step(0, 0, 1, 32'h33, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // backpressure into the skid entry, then drain in order
    step(0, 0, 1, 32'hA0, 0);
    step(0, 0, 1, 32'hA1, 0);
    chk("skid_occ", 32'(occupancy), 32'd2);
    step(0, 0, 1, 32'hA2, 0);
    step(0, 0, 1, 32'hA2, 1);
    step(0, 0, 1, 32'hA2, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // flush with keep mask, two entries held
    do_reset();
    step(0, 0, 1, 32'hB0, 0);
    step(0, 0, 1, 32'hB1, 0);
    step(1, 0, 0, 32'h1234ABCD, 0);
    chk("flush_data", out_data, 32'h12340013);
    chk("flush_cnt1", 32'(flush_cnt), 32'd1);
    step(0, 0, 0, 32'h0, 0);
    // flush beats stall
    do_reset();
    step(0, 0, 1, 32'hC0, 0);
    step(1, 1, 1, 32'hFFFF_FFFF, 1);
    chk("fs_stall_cnt", 32'(stall_cnt), 32'd0);
    step(0, 0, 0, 32'h0, 0);
    // stall holds the stage
    do_reset();
    step(0, 0, 1, 32'h55, 0);
    repeat (3) step(0, 1, 1, 32'h66, 1);
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
    chk("stall_hold", out_data, 32'h55);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // counter saturation
    do_reset();
    repeat (5) step(0, 1, 0, 32'h0, 0);
    chk("stall_sat", 32'(stall_cnt), 32'd3);
    repeat (5) step(1, 0, 0, 32'h0, 0);
    chk("flush_sat", 32'(flush_cnt), 32'd3);
    // async reset with two entries held
    step(0, 0, 1, 32'hD0, 0);
    step(0, 0, 1, 32'hD1, 0);
    #2 rst_n = 0;
    #1;
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", out_data, BUB);
    chk("ar_fcnt", 32'(flush_cnt), 32'd0);
    chk("ar_scnt", 32'(stall_cnt), 32'd0);
    do_reset();
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(15) == 0, $urandom_range(7) == 0, 1'($urandom), $urandom, 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload of DATA_W bits with a valid/ready handshake and a 2-entry skid buffer, so ready is registered and full throughput is kept.
- Flush inserts a bubble; bits selected by a mask (e.g. the PC field) are preserved from the input. Stall holds the stage.
- Saturating flush and stall event counters support performance debug.

Parameters:
- DATA_W, 64, payload width in bits (≥1).
- BUBBLE, {DATA_W{1'b0}}, payload value presented for an empty or flushed stage (e.g. ADDI x0 NOP encoding).
- KEEP_MASK, {DATA_W{1'b0}}, payload bits taken from in_data instead of BUBBLE when a flush occurs.
- CNT_W, 16, width of the event counters.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, discard all held entries and insert a bubble.
- stall, in, 1, freeze the stage: no input or output transfer.
- in_valid, in, 1, upstream payload valid.
- in_ready, out, 1, stage can accept a payload.
- in_data, in, DATA_W, upstream payload.
- out_valid, out, 1, stage holds a valid payload.
- out_ready, in, 1, downstream accepts the payload.
- out_data, out, DATA_W, payload at the head of the stage.
- occupancy, out, 2, number of held entries (0..2).
- flush_cnt, out, CNT_W, saturating count of cycles with flush=1.
- stall_cnt, out, CNT_W, saturating count of cycles with stall=1 and flush=0.

Behaviour:
- Storage:
  - main entry (head, drives out_data) and skid entry, each with a valid bit.
  - States: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
- Reset (async, rst_n=0):
  - Both valid bits clear; main data = BUBBLE; counters = 0.
  - Outputs: out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0.
  - Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Handshake:
  - in_ready = !skid_valid && !stall. The skid-valid term is registered; stall gating is the only combinational path.
  - out_valid = main_valid; out_data = main data.
  - Accept = in_valid && in_ready. Issue = out_valid && out_ready && !stall.
  - in_valid must not depend on in_ready; out_ready may depend on out_valid.
- Transitions (flush=0, stall=0):
  - EMPTY + accept -> ONE; main <= in_data. Latency is 1 cycle from accept to out_valid.
  - ONE + accept + issue -> ONE; main <= in_data.
  - ONE + issue only -> EMPTY; main data <= BUBBLE.
  - ONE + accept, no issue -> TWO; skid <= in_data.
  - TWO + issue -> ONE; main <= skid. No accept is possible because in_ready=0.
  - Otherwise the state holds.
  - Ordering is strictly FIFO; no payload is dropped or duplicated.
- Stall (flush=0):
  - All state and data hold, regardless of in_valid and out_ready.
  - out_valid and out_data stay stable.
  - stall_cnt increments.
- Flush (highest priority; overrides stall and any handshake in the same cycle):
  - Next state: both entries invalid (EMPTY).
  - main data <= (BUBBLE & ~KEEP_MASK) | (in_data & KEEP_MASK), sampled that cycle whether or not in_valid=1.
  - No accept occurs that cycle even if in_ready=1; upstream must treat the payload as killed.
  - No issue is counted; downstream must ignore out_valid in a flush cycle.
  - flush_cnt increments; stall_cnt does not.
- Priority: rst_n > flush > stall > normal transfer.
- Counters:
  - CNT_W-bit, saturate at all-ones (no wrap-around).
  - Cleared only by reset.
- Arithmetic: occupancy = main_valid + skid_valid, zero-extended to 2 bits. skid_valid=1 implies main_valid=1 (invariant; assert in the bench).

Test Plan:
- Streaming: DATA_W=32, out_ready=1, send 0x11,0x22,0x33 on back-to-back cycles -> out_data 0x11,0x22,0x33 on the following consecutive cycles; in_ready stays 1; occupancy ≤1.
- Backpressure/skid: out_ready=0, send 0xA0 then 0xA1 -> occupancy=2, in_ready=0 from the next edge, 0xA2 is held upstream; release out_ready -> 0xA0,0xA1,0xA2 in order, no loss.
- Flush with keep: BUBBLE=0x00000013, KEEP_MASK=0xFFFF0000, two entries held, flush=1 with in_data=0x1234ABCD -> next cycle out_valid=0, out_data=0x12340013, occupancy=0, flush_cnt=1.
- Flush vs stall: flush=1 and stall=1 in the same cycle with one entry held -> flush wins: occupancy=0, flush_cnt+1, stall_cnt unchanged.
- Stall hold: entry 0x55 held, stall=1 for 3 cycles with out_ready=1 and in_valid=1 -> out_data stays 0x55 and out_valid=1, in_ready=0, stall_cnt=3; stall=0 -> 0x55 issues.
- Saturation/reset: CNT_W=2, stall for 5 cycles -> stall_cnt=3; assert rst_n=0 asynchronously with occupancy=2 -> immediately occupancy=0, out_valid=0, out_data=BUBBLE, counters=0.
